core_run_ctrl: RTL and testbench

Synthesizable run/step/halt controller for the pipelined core. It replaces free-running clock generation and the fixed stop time with a parametrised cycle-enable generator. It produces a divided core enable (`core_en`) plus an observation clock (`real_clk`), counts executed core cycles, and stops the core on a halt request, a cycle-limit timeout, or an optional PC breakpoint. It sits between CLOCK_50 and the pipeline's clock-enable input; host logic or the bench drives run/step/clear.

---
 rtl/core_run_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_core_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run/step/halt cycle-enable controller for the pipelined core
// Optional breakpoint logic is built when RUN_CTRL_BKPT_EN is defined.
module core_run_ctrl #(
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CYCLES = 200
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic                 clr,
`ifdef RUN_CTRL_BKPT_EN
  input  logic [31:0]          pc_in,
  input  logic [31:0]          bkpt_pc,
  input  logic                 bkpt_valid,
  output logic                 bkpt_hit,
`endif
  output logic                 core_en,
  output logic                 real_clk,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [1:0]           state,
  output logic                 done,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   CNT_ONE  = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH:0]   MAX_C    = (CNT_WIDTH+1)'(MAX_CYCLES);
  localparam bit                   LIMIT_EN = (MAX_CYCLES != 0);

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic                   core_en_q, core_en_d;
  logic                   real_clk_q, real_clk_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   step_q;
`ifdef RUN_CTRL_BKPT_EN
  logic                   bkpt_hit_q, bkpt_hit_d;
`endif

  logic                   active;
  logic                   next_active;
  logic                   tick;
  logic                   step_rise;
  logic                   pulse_ok;
  logic                   stop_req;
  logic                   bkpt_trip;
  logic                   issue;
  logic                   limit_hit;
  logic [CNT_WIDTH:0]     cnt_inc;

  // Decode of the current cycle: divider tick, pending stop requests and whether a pulse goes out.
  always_comb begin
    active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    tick      = (div_cnt_q >= div_sel);
    step_rise = step & ~step_q;
`ifdef RUN_CTRL_BKPT_EN
    bkpt_trip = bkpt_valid && (pc_in == bkpt_pc) && (state_q == ST_RUN);
`else
    bkpt_trip = 1'b0;
`endif
    stop_req  = halt_req | bkpt_trip;
    // A paused RUN (run dropped) leaves the count and observation clock untouched.
    pulse_ok  = ((state_q == ST_RUN) && run) || (state_q == ST_STEP);
    issue     = tick & pulse_ok & ~stop_req;
    cnt_inc   = {1'b0, cnt_q} + CNT_ONE;
    limit_hit = LIMIT_EN && (cnt_inc == MAX_C);
  end

  // Next-state and datapath updates, highest-priority condition first.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = '0;
    core_en_d  = 1'b0;
    real_clk_d = real_clk_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    next_active = 1'b0;
`ifdef RUN_CTRL_BKPT_EN
    bkpt_hit_d = bkpt_hit_q;
`endif

    if (clr) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
`ifdef RUN_CTRL_BKPT_EN
      bkpt_hit_d = 1'b0;
`endif
    end else if (active && stop_req) begin
      state_d = ST_HALTED;
`ifdef RUN_CTRL_BKPT_EN
      bkpt_hit_d = bkpt_hit_q | bkpt_trip;
`endif
    end else begin
      if (issue) begin
        core_en_d  = 1'b1;
        real_clk_d = ~real_clk_q;
        if (!(&cnt_q)) begin
          cnt_d = cnt_inc[CNT_WIDTH-1:0];
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d = ST_RUN;
          end else if (step_rise) begin
            state_d = ST_STEP;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_d = ST_IDLE;
          end
        end
        ST_STEP: begin
          if (tick) begin
            state_d = ST_IDLE;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // The pulse that reaches the cycle limit is still issued, then the core stops.
      if (issue && limit_hit) begin
        state_d   = ST_HALTED;
        timeout_d = 1'b1;
      end

      // The divider only runs while staying in an active state; any entry or exit restarts it.
      next_active = (state_d == ST_RUN) || (state_d == ST_STEP);
      if (active && next_active) begin
        div_cnt_d = tick ? '0 : (div_cnt_q + DIV_ONE);
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      core_en_q  <= 1'b0;
      real_clk_q <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      step_q     <= 1'b0;
`ifdef RUN_CTRL_BKPT_EN
      bkpt_hit_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      core_en_q  <= core_en_d;
      real_clk_q <= real_clk_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      step_q     <= step;
`ifdef RUN_CTRL_BKPT_EN
      bkpt_hit_q <= bkpt_hit_d;
`endif
    end
  end

  assign core_en     = core_en_q;
  assign real_clk    = real_clk_q;
  assign cycle_count = cnt_q;
  assign state       = state_q;
  assign done        = (state_q == ST_HALTED);
  assign timeout     = timeout_q;
`ifdef RUN_CTRL_BKPT_EN
  assign bkpt_hit    = bkpt_hit_q;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - scoreboard bench for core_run_ctrl
module tb_core_run_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic [7:0]  div_sel;
  logic        run, step, halt_req, clr;
  logic        core_en, real_clk, done, timeout;
  logic [31:0] cycle_count;
  logic [1:0]  state;
`ifdef RUN_CTRL_BKPT_EN
  logic [31:0] pc_in, bkpt_pc;
  logic        bkpt_valid, bkpt_hit;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          cyc = 0;
  int          last_pulse = -1;
  int          period = 0;
  logic        rc_exp = 1'b0;

  core_run_ctrl #(.DIV_WIDTH(8), .CNT_WIDTH(32), .MAX_CYCLES(200)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .div_sel     (div_sel),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .clr         (clr),
`ifdef RUN_CTRL_BKPT_EN
    .pc_in       (pc_in),
    .bkpt_pc     (bkpt_pc),
    .bkpt_valid  (bkpt_valid),
    .bkpt_hit    (bkpt_hit),
`endif
    .core_en     (core_en),
    .real_clk    (real_clk),
    .cycle_count (cycle_count),
    .state       (state),
    .done        (done),
    .timeout     (timeout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Pulse monitor: every core_en pulse pops the expected count from the scoreboard.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (reset_n === 1'b1 && core_en === 1'b1) begin
        rc_exp = ~rc_exp;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cycle_count=%0d, no pulse expected", cycle_count);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cycle_count !== mon_exp) begin
            errors++;
            $display("FAIL pulse_count: got %0d want %0d", cycle_count, mon_exp);
          end
        end
        checks++;
        if (real_clk !== rc_exp) begin
          errors++;
          $display("FAIL real_clk: got %0b want %0b", real_clk, rc_exp);
        end
        if (period != 0 && last_pulse >= 0) begin
          checks++;
          if (cyc - last_pulse != period) begin
            errors++;
            $display("FAIL pulse_spacing: got %0d want %0d", cyc - last_pulse, period);
          end
        end
        last_pulse = cyc;
      end
    end
  end

  task automatic push_range(input int a, input int b);
    for (int i = a; i <= b; i++) exp_q.push_back(32'(i));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    halt_req = 1'b0;
    clr      = 1'b0;
    div_sel  = 8'd0;
`ifdef RUN_CTRL_BKPT_EN
    pc_in      = 32'd0;
    bkpt_pc    = 32'd0;
    bkpt_valid = 1'b0;
`endif
    repeat (3) @(negedge CLOCK_50);
    rc_exp     = 1'b0;
    last_pulse = -1;
    period     = 0;
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge CLOCK_50);
    clr = 1'b0;
    @(negedge CLOCK_50);
    last_pulse = -1;
    exp_q.delete();
  endtask

  task automatic wait_count(input logic [31:0] target, input int bound, input string name);
    int n = 0;
    while (cycle_count !== target && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: cycle_count=%0d never reached %0d", name, cycle_count, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0)       begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (core_en !== 1'b0)     begin errors++; $display("FAIL reset_core_en: got %0b want 0", core_en); end
    checks++; if (real_clk !== 1'b0)    begin errors++; $display("FAIL reset_real_clk: got %0b want 0", real_clk); end
    checks++; if (cycle_count !== 0)    begin errors++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    checks++; if (timeout !== 1'b0)     begin errors++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
  endtask

  task automatic test_timeout();
    int n = 0;
    div_sel = 8'd0;
    period  = 1;
    last_pulse = -1;
    push_range(1, 200);
    run = 1'b1;
    while (done !== 1'b1 && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++; if (n >= 400) begin errors++; $display("FAIL timeout_wait: done never rose, count=%0d", cycle_count); end
    repeat (50) @(negedge CLOCK_50);
    checks++; if (cycle_count !== 200) begin errors++; $display("FAIL timeout_count: got %0d want 200", cycle_count); end
    checks++; if (timeout !== 1'b1)    begin errors++; $display("FAIL timeout_flag: got %0b want 1", timeout); end
    checks++; if (state !== 2'd3)      begin errors++; $display("FAIL timeout_state: got %0d want 3", state); end
    checks++; if (done !== 1'b1)       begin errors++; $display("FAIL timeout_done: got %0b want 1", done); end
    checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL timeout_pulses: %0d pulses missing want 0", exp_q.size()); end
    period = 0;
    run = 1'b0;
    do_clr();
    checks++; if (state !== 2'd0)      begin errors++; $display("FAIL clr_state: got %0d want 0", state); end
    checks++; if (cycle_count !== 0)   begin errors++; $display("FAIL clr_count: got %0d want 0", cycle_count); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL clr_timeout: got %0b want 0", timeout); end
  endtask

  task automatic test_divider();
    div_sel = 8'd3;
    period  = 4;
    last_pulse = -1;
    push_range(1, 20);
    run = 1'b1;
    repeat (38) @(negedge CLOCK_50);
    checks++;
    if (cycle_count < 9 || cycle_count > 10) begin
      errors++; $display("FAIL div_count: got %0d want 9..10", cycle_count);
    end
    run = 1'b0;
    period = 0;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL div_pause_state: got %0d want 0", state); end
    do_clr();
  endtask

  task automatic test_step();
    div_sel = 8'd2;
    push_range(1, 3);
    for (int r = 0; r < 3; r++) begin
      step = 1'b1;
      @(negedge CLOCK_50);
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL step_enter: got %0d want 2", state); end
      repeat (4) @(negedge CLOCK_50);
      step = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL step_return: got %0d want 0", state); end
      checks++; if (cycle_count !== 32'(r + 1)) begin errors++; $display("FAIL step_count: got %0d want %0d", cycle_count, r + 1); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL step_pulses: %0d missing want 0", exp_q.size()); end
    do_clr();
  endtask

  task automatic test_halt();
    div_sel = 8'd0;
    push_range(1, 10);
    run = 1'b1;
    wait_count(32'd10, 100, "halt_wait");
    halt_req = 1'b1;
    @(negedge CLOCK_50);
    halt_req = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    checks++; if (state !== 2'd3)      begin errors++; $display("FAIL halt_state: got %0d want 3", state); end
    checks++; if (done !== 1'b1)       begin errors++; $display("FAIL halt_done: got %0b want 1", done); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL halt_timeout: got %0b want 0", timeout); end
    checks++; if (cycle_count !== 10)  begin errors++; $display("FAIL halt_count: got %0d want 10", cycle_count); end
    run = 1'b0;
    do_clr();
    checks++; if (state !== 2'd0)      begin errors++; $display("FAIL halt_clr_state: got %0d want 0", state); end
    checks++; if (cycle_count !== 0)   begin errors++; $display("FAIL halt_clr_count: got %0d want 0", cycle_count); end
  endtask

  task automatic test_pause_and_async_reset();
    div_sel = 8'd1;
    period  = 2;
    last_pulse = -1;
    push_range(1, 31);
    run = 1'b1;
    wait_count(32'd20, 200, "pause_wait");
    run = 1'b0;
    period = 0;
    repeat (30) @(negedge CLOCK_50);
    checks++; if (cycle_count !== 20) begin errors++; $display("FAIL pause_count: got %0d want 20", cycle_count); end
    checks++; if (state !== 2'd0)     begin errors++; $display("FAIL pause_state: got %0d want 0", state); end
    run = 1'b1;
    wait_count(32'd31, 200, "resume_wait");
    checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL resume_pulses: %0d missing want 0", exp_q.size()); end
    #5;
    reset_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0)     begin errors++; $display("FAIL async_state: got %0d want 0", state); end
    checks++; if (core_en !== 1'b0)   begin errors++; $display("FAIL async_core_en: got %0b want 0", core_en); end
    checks++; if (real_clk !== 1'b0)  begin errors++; $display("FAIL async_real_clk: got %0b want 0", real_clk); end
    checks++; if (cycle_count !== 0)  begin errors++; $display("FAIL async_count: got %0d want 0", cycle_count); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL async_done: got %0b want 0", done); end
    do_reset();
  endtask

`ifdef RUN_CTRL_BKPT_EN
  task automatic test_bkpt();
    int n = 0;
    div_sel    = 8'd0;
    pc_in      = 32'd0;
    bkpt_pc    = 32'h40;
    bkpt_valid = 1'b1;
    push_range(1, 16);
    run = 1'b1;
    while (state !== 2'd3 && n < 100) begin
      @(negedge CLOCK_50);
      if (core_en === 1'b1) pc_in = pc_in + 32'd4;
      n++;
    end
    checks++; if (n >= 100)            begin errors++; $display("FAIL bkpt_wait: never halted, count=%0d", cycle_count); end
    repeat (3) @(negedge CLOCK_50);
    checks++; if (pc_in !== 32'h40)    begin errors++; $display("FAIL bkpt_pc: got %0h want 40", pc_in); end
    checks++; if (bkpt_hit !== 1'b1)   begin errors++; $display("FAIL bkpt_hit: got %0b want 1", bkpt_hit); end
    checks++; if (cycle_count !== 16)  begin errors++; $display("FAIL bkpt_count: got %0d want 16", cycle_count); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL bkpt_timeout: got %0b want 0", timeout); end
    run = 1'b0;
    bkpt_valid = 1'b0;
    do_clr();
    checks++; if (bkpt_hit !== 1'b0)   begin errors++; $display("FAIL bkpt_clr: got %0b want 0", bkpt_hit); end
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_divider();
    test_step();
    test_halt();
    test_pause_and_async_reset();
`ifdef RUN_CTRL_BKPT_EN
    test_bkpt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
